// File: rtl/control_unit_param_if.sv
// Control bundle between the sequencer and the register-file/ALU datapath.
// master = control unit (drives enables/selects), slave = datapath side (drives run/instruction).
interface control_unit_param_if #(
    parameter int NUM_REGS = 8,
    parameter int INST_W   = 16,
    parameter int ALU_W    = 3
);
    localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int IW = INST_W - 2*RW - 2;

    logic                run;
    logic [INST_W-1:0]   reg_inst;
    logic                en_i;
    logic                en_s;
    logic                en_c;
    logic [NUM_REGS-1:0] en_r;
    logic [RW-1:0]       mux_sel;
    logic [1:0]          wb_src;
    logic [IW-1:0]       imm;
    logic [ALU_W-1:0]    alu_sel;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        input  run, reg_inst,
        output en_i, en_s, en_c, en_r, mux_sel, wb_src, imm, alu_sel, busy, done, err
    );

    modport slave (
        output run, reg_inst,
        input  en_i, en_s, en_c, en_r, mux_sel, wb_src, imm, alu_sel, busy, done, err
    );
endinterface

// File: rtl/control_unit_param.sv
// Multi-cycle sequencer: fetch -> decode -> (load S, exec C) -> write-back, or error pulse.
// Latency: done FETCH_WAIT+5 cycles after run (ALU), FETCH_WAIT+3 (MV/MVI/illegal); run ignored while busy.
module control_unit_param #(
    parameter int NUM_REGS   = 8,
    parameter int INST_W     = 16,
    parameter int ALU_W      = 3,
    parameter int FETCH_WAIT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    control_unit_param_if.master  bus
);
    localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int IW = INST_W - 2*RW - 2;

    localparam logic [1:0] OP_ALU = 2'b00;
    localparam logic [1:0] OP_MV  = 2'b01;
    localparam logic [1:0] OP_MVI = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_LOAD_S, S_EXEC_C, S_WB, S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic [RW-1:0]    rx_q, rx_d, ry_q, ry_d;
    logic [1:0]       op_q, op_d;
    logic [ALU_W-1:0] alu_q, alu_d;
    logic [IW-1:0]    imm_q, imm_d;

    logic [RW-1:0]    rx_f, ry_f;
    logic [1:0]       op_f;
    logic             rx_bad, ry_bad, fetch_last;

    logic                en_i_w, en_s_w, en_c_w, busy_w, done_w, err_w;
    logic [NUM_REGS-1:0] en_r_w;
    logic [RW-1:0]       mux_w;
    logic [1:0]          wb_w;
    logic [ALU_W-1:0]    alu_w;
    logic [IW-1:0]       imm_w;

    assign rx_f       = bus.reg_inst[INST_W-1 -: RW];
    assign ry_f       = bus.reg_inst[INST_W-1-RW -: RW];
    assign op_f       = bus.reg_inst[INST_W-1-2*RW -: 2];
    assign rx_bad     = (32'(rx_f) >= 32'(NUM_REGS));
    assign ry_bad     = (32'(ry_f) >= 32'(NUM_REGS));
    assign fetch_last = (wait_q == 4'(FETCH_WAIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
            op_q    <= '0;
            alu_q   <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            op_q    <= op_d;
            alu_q   <= alu_d;
            imm_q   <= imm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        op_d    = op_q;
        alu_d   = alu_q;
        imm_d   = imm_q;
        en_i_w  = 1'b0;
        en_s_w  = 1'b0;
        en_c_w  = 1'b0;
        en_r_w  = '0;
        mux_w   = '0;
        wb_w    = 2'b00;
        alu_w   = '0;
        done_w  = 1'b0;
        err_w   = 1'b0;

        case (state_q)
            S_IDLE: begin
                wait_d = '0;
                if (bus.run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (fetch_last) begin
                    en_i_w  = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_DECODE: begin
                // Fields are frozen here so later reg_inst changes cannot disturb this instruction
                rx_d  = rx_f;
                ry_d  = ry_f;
                op_d  = op_f;
                alu_d = bus.reg_inst[ALU_W+1:2];
                imm_d = bus.reg_inst[IW-1:0];
                if (op_f == OP_ILL || rx_bad || (op_f != OP_MVI && ry_bad))
                    state_d = S_ERR;
                else if (op_f == OP_ALU)
                    state_d = S_LOAD_S;
                else
                    state_d = S_WB;
            end
            S_LOAD_S: begin
                en_s_w  = 1'b1;
                mux_w   = rx_q;
                state_d = S_EXEC_C;
            end
            S_EXEC_C: begin
                en_c_w  = 1'b1;
                mux_w   = ry_q;
                alu_w   = alu_q;
                state_d = S_WB;
            end
            S_WB: begin
                for (int i = 0; i < NUM_REGS; i++) en_r_w[i] = (rx_q == RW'(i));
                done_w = 1'b1;
                if (op_q == OP_ALU)     wb_w = 2'b01;
                else if (op_q == OP_MV) mux_w = ry_q;
                else                    wb_w = 2'b10;
                state_d = S_IDLE;
            end
            S_ERR: begin
                done_w  = 1'b1;
                err_w   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_w = (state_q != S_IDLE);
        imm_w  = busy_w ? imm_q : '0;
    end

    assign bus.en_i    = en_i_w;
    assign bus.en_s    = en_s_w;
    assign bus.en_c    = en_c_w;
    assign bus.en_r    = en_r_w;
    assign bus.mux_sel = mux_w;
    assign bus.wb_src  = wb_w;
    assign bus.imm     = imm_w;
    assign bus.alu_sel = alu_w;
    assign bus.busy    = busy_w;
    assign bus.done    = done_w;
    assign bus.err     = err_w;
endmodule

// File: tb/tb_control_unit_param.sv
// Directed vectors against three configurations: default, FETCH_WAIT=3, NUM_REGS=6.
module tb_control_unit_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    control_unit_param_if #(.NUM_REGS(8), .INST_W(16), .ALU_W(3)) if0 ();
    control_unit_param_if #(.NUM_REGS(8), .INST_W(16), .ALU_W(3)) if1 ();
    control_unit_param_if #(.NUM_REGS(6), .INST_W(16), .ALU_W(3)) if2 ();

    control_unit_param #(.NUM_REGS(8), .INST_W(16), .ALU_W(3), .FETCH_WAIT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    control_unit_param #(.NUM_REGS(8), .INST_W(16), .ALU_W(3), .FETCH_WAIT(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    control_unit_param #(.NUM_REGS(6), .INST_W(16), .ALU_W(3), .FETCH_WAIT(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    typedef struct packed {
        logic       en_i, en_s, en_c;
        logic [7:0] en_r;
        logic [2:0] mux;
        logic [1:0] wb;
        logic [7:0] imm;
        logic [2:0] alu;
        logic       busy, done, err;
    } snap_t;

    typedef struct {
        int         d;
        logic [15:0] inst;
        int         eni, ens, enc, dn;
        logic       err;
        logic [7:0] en_r;
        logic [1:0] wb;
        logic [2:0] mux_wb;
        logic [7:0] imm;
        logic [2:0] mux_s, mux_c, alu_c;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic snap_t snap(input int d);
        snap_t s;
        case (d)
            0: s = '{if0.en_i, if0.en_s, if0.en_c, if0.en_r, if0.mux_sel, if0.wb_src, if0.imm,
                     if0.alu_sel, if0.busy, if0.done, if0.err};
            1: s = '{if1.en_i, if1.en_s, if1.en_c, if1.en_r, if1.mux_sel, if1.wb_src, if1.imm,
                     if1.alu_sel, if1.busy, if1.done, if1.err};
            default: s = '{if2.en_i, if2.en_s, if2.en_c, {2'b00, if2.en_r}, if2.mux_sel, if2.wb_src,
                           if2.imm, if2.alu_sel, if2.busy, if2.done, if2.err};
        endcase
        return s;
    endfunction

    task automatic drive(input int d, input logic run, input logic [15:0] inst);
        case (d)
            0: begin if0.run = run; if0.reg_inst = inst; end
            1: begin if1.run = run; if1.reg_inst = inst; end
            default: begin if2.run = run; if2.reg_inst = inst; end
        endcase
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Entered just after a rising edge; that cycle is c0 with run asserted.
    task automatic run_vec(input vec_t v, input int idx);
        snap_t s;
        int eni = -1, ens = -1, enc = -1, dn = -1, rpulses = 0, excl = 0, busy0 = -1;
        logic err_d = 1'b0;
        logic [7:0] enr_d = '0, imm_d = '0;
        logic [1:0] wb_d = '0;
        logic [2:0] mux_d = '0, mux_s = '0, mux_c = '0, alu_c = '0;
        string tag;
        tag = $sformatf("v%0d", idx);
        drive(v.d, 1'b1, v.inst);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            s = snap(v.d);
            if (k == 0) busy0 = int'(s.busy);
            if (s.en_i && eni < 0) eni = k;
            if (s.en_s && ens < 0) begin ens = k; mux_s = s.mux; end
            if (s.en_c && enc < 0) begin enc = k; mux_c = s.mux; alu_c = s.alu; end
            if (s.done && dn < 0) begin
                dn = k; err_d = s.err; enr_d = s.en_r; wb_d = s.wb; mux_d = s.mux; imm_d = s.imm;
            end
            if (s.en_r != 0) rpulses++;
            if (!$onehot0(s.en_r) || (int'(s.en_i) + int'(s.en_s) + int'(s.en_c) + int'(s.en_r != 0)) > 1)
                excl++;
            next_cycle();
            drive(v.d, 1'b0, v.inst);
        end
        chk({tag, " busy_c0"}, busy0, 0);
        chk({tag, " en_i_cyc"}, eni, v.eni);
        chk({tag, " en_s_cyc"}, ens, v.ens);
        chk({tag, " en_c_cyc"}, enc, v.enc);
        chk({tag, " done_cyc"}, dn, v.dn);
        chk({tag, " err"}, err_d, v.err);
        chk({tag, " en_r"}, enr_d, v.en_r);
        chk({tag, " wb_src"}, wb_d, v.wb);
        chk({tag, " mux_wb"}, mux_d, v.mux_wb);
        chk({tag, " imm"}, imm_d, v.imm);
        chk({tag, " mux_s"}, mux_s, v.mux_s);
        chk({tag, " mux_c"}, mux_c, v.mux_c);
        chk({tag, " alu_c"}, alu_c, v.alu_c);
        chk({tag, " en_r_pulses"}, rpulses, v.err ? 0 : 1);
        chk({tag, " exclusive"}, excl, 0);
    endtask

    vec_t vecs[12];

    initial begin
        snap_t s;
        int dcyc[3];
        logic [7:0] denr[3];
        int ndone, nbusy, nenr;

        // 16-bit layout: rX[15:13] rY[12:10] op[9:8] imm[7:0], alu = inst[4:2]
        vecs[0]  = '{0, 16'h540C, 1,  3,  4, 5, 1'b0, 8'h04, 2'b01, 3'd0, 8'h0C, 3'd2, 3'd5, 3'd3};
        vecs[1]  = '{0, 16'hE014, 1,  3,  4, 5, 1'b0, 8'h80, 2'b01, 3'd0, 8'h14, 3'd7, 3'd0, 3'd5};
        vecs[2]  = '{0, 16'hE500, 1, -1, -1, 3, 1'b0, 8'h80, 2'b00, 3'd1, 8'h00, 3'd0, 3'd0, 3'd0};
        vecs[3]  = '{0, 16'h022A, 1, -1, -1, 3, 1'b0, 8'h01, 2'b10, 3'd0, 8'h2A, 3'd0, 3'd0, 3'd0};
        vecs[4]  = '{0, 16'h82FF, 1, -1, -1, 3, 1'b0, 8'h10, 2'b10, 3'd0, 8'hFF, 3'd0, 3'd0, 3'd0};
        vecs[5]  = '{0, 16'h6300, 1, -1, -1, 3, 1'b1, 8'h00, 2'b00, 3'd0, 8'h00, 3'd0, 3'd0, 3'd0};
        vecs[6]  = '{1, 16'h022A, 4, -1, -1, 6, 1'b0, 8'h01, 2'b10, 3'd0, 8'h2A, 3'd0, 3'd0, 3'd0};
        vecs[7]  = '{1, 16'h540C, 4,  6,  7, 8, 1'b0, 8'h04, 2'b01, 3'd0, 8'h0C, 3'd2, 3'd5, 3'd3};
        vecs[8]  = '{2, 16'hC500, 1, -1, -1, 3, 1'b1, 8'h00, 2'b00, 3'd0, 8'h00, 3'd0, 3'd0, 3'd0};
        vecs[9]  = '{2, 16'h3C00, 1, -1, -1, 3, 1'b1, 8'h00, 2'b00, 3'd0, 8'h00, 3'd0, 3'd0, 3'd0};
        vecs[10] = '{2, 16'hBE03, 1, -1, -1, 3, 1'b0, 8'h20, 2'b10, 3'd0, 8'h03, 3'd0, 3'd0, 3'd0};
        vecs[11] = '{2, 16'h540C, 1,  3,  4, 5, 1'b0, 8'h04, 2'b01, 3'd0, 8'h0C, 3'd2, 3'd5, 3'd3};

        for (int d = 0; d < 3; d++) drive(d, 1'b1, 16'h540C);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk($sformatf("reset_outputs_d%0d", d), 32'(snap(d)), 0);
        next_cycle();
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 16'h0000);
        rst_n = 1'b1;
        next_cycle();

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // run held high: three instructions, reg_inst changed right after the first DECODE
        ndone = 0;
        drive(0, 1'b1, 16'h540C);
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            s = snap(0);
            if (s.done) begin
                if (ndone < 3) begin dcyc[ndone] = k; denr[ndone] = s.en_r; end
                ndone++;
            end
            next_cycle();
            if (k == 2)  drive(0, 1'b1, 16'hE014);
            if (k == 16) drive(0, 1'b0, 16'hE014);
        end
        chk("b2b_done_count", ndone, 3);
        if (ndone >= 3) begin
            chk("b2b_done0_cyc", dcyc[0], 5);
            chk("b2b_done1_cyc", dcyc[1], 11);
            chk("b2b_done2_cyc", dcyc[2], 17);
            chk("b2b_en_r0", denr[0], 8'h04);
            chk("b2b_en_r1", denr[1], 8'h80);
            chk("b2b_en_r2", denr[2], 8'h80);
        end

        // run pulse while busy must not start a second instruction
        ndone = 0; nbusy = 0;
        drive(0, 1'b1, 16'hE500);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            s = snap(0);
            if (s.done) ndone++;
            if (s.busy) nbusy++;
            next_cycle();
            drive(0, (k == 1), 16'hE500);
        end
        chk("busy_run_done_count", ndone, 1);
        chk("busy_run_busy_cycles", nbusy, 3);

        // reset asserted in EXEC_C, then released: no late write-back
        drive(0, 1'b1, 16'h540C);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            next_cycle();
            drive(0, 1'b0, 16'h540C);
        end
        @(negedge clk);
        chk("pre_reset_en_c", snap(0).en_c, 1'b1);
        next_cycle();
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", 32'(snap(0)), 0);
        @(negedge clk);
        chk("mid_reset_hold", 32'(snap(0)), 0);
        next_cycle();
        rst_n = 1'b1;
        nenr = 0; nbusy = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            s = snap(0);
            if (s.en_r != 0) nenr++;
            if (s.busy) nbusy++;
        end
        chk("post_reset_en_r", nenr, 0);
        chk("post_reset_busy", nbusy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
